// File: rtl/aes_gf_mac.sv
// GF(2^WIDTH) SUM/MUL/MAC/CLR engine with constant-time bit-serial multiply (MSB first).
// Define AES_GF_MAC_ACC_EN to build the accumulator; otherwise MAC acts as MUL and CLR only returns 0.
module aes_gf_mac #(
  parameter int             WIDTH = 8,
  parameter logic [WIDTH:0] POLY  = 9'h11B
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic [1:0]       op_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] result_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [1:0] {OP_SUM = 2'd0, OP_MUL = 2'd1, OP_MAC = 2'd2, OP_CLR = 2'd3} op_e;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              w_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             w_last;
  logic [WIDTH-1:0] w_xtime;
  logic [WIDTH-1:0] w_p_nxt;
  logic [WIDTH-1:0] w_final;

  assign w_op    = op_e'(op_i);
  assign w_last  = (r_cnt == '0);
  // Bit WIDTH of POLY cancels the shifted-out bit, so only the low bits are XORed in.
  assign w_xtime = {r_p[WIDTH-2:0], 1'b0} ^ (r_p[WIDTH-1] ? POLY[WIDTH-1:0] : '0);
  assign w_p_nxt = w_xtime ^ (r_b[r_cnt] ? r_a : '0);

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign result_o    = r_result;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid_i)
                w_state_nxt = (w_op == OP_MUL || w_op == OP_MAC) ? S_BUSY : S_DONE;
      S_BUSY: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid_i) begin
          r_a   <= operand_a_i;
          r_b   <= operand_b_i;
          r_p   <= '0;
          r_cnt <= CW'(WIDTH - 1);
          if (w_op == OP_SUM)      r_result <= operand_a_i ^ operand_b_i;
          else if (w_op == OP_CLR) r_result <= '0;
        end
        S_BUSY: begin
          r_p   <= w_p_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_GF_MAC_ACC_EN
  logic [WIDTH-1:0] r_acc;
  logic             r_mac;

  assign w_final = r_mac ? (r_acc ^ w_p_nxt) : w_p_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_mac <= 1'b0;
    end else if (r_state == S_IDLE && in_valid_i) begin
      r_mac <= (w_op == OP_MAC);
      if (w_op == OP_CLR) r_acc <= '0;
    end else if (r_state == S_BUSY && w_last && r_mac) begin
      r_acc <= r_acc ^ w_p_nxt;
    end
  end
`else
  assign w_final = w_p_nxt;
`endif

endmodule

// File: tb/tb_aes_gf_mac.sv
// Self-checking bench for aes_gf_mac: an 8-bit/0x11B and a 4-bit/0x13 instance against a
// polynomial-arithmetic reference model (follows AES_GF_MAC_ACC_EN for accumulator behaviour).
module tb_aes_gf_mac;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_i, b_i;
  logic [1:0] op;
  logic       v8, v4, ordy;
  logic       rdy8, ov8, rdy4, ov4;
  logic [7:0] res8;
  logic [3:0] res4;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] m_acc[2];

  always #5 clk = ~clk;

  aes_gf_mac #(.WIDTH(8), .POLY(9'h11B)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .operand_a_i(a_i), .operand_b_i(b_i), .op_i(op),
    .in_valid_i(v8), .in_ready_o(rdy8), .result_o(res8), .out_valid_o(ov8), .out_ready_i(ordy)
  );

  aes_gf_mac #(.WIDTH(4), .POLY(5'h13)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .operand_a_i(a_i[3:0]), .operand_b_i(b_i[3:0]), .op_i(op),
    .in_valid_i(v4), .in_ready_o(rdy4), .result_o(res4), .out_valid_o(ov4), .out_ready_i(ordy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 1) ? rdy4 : rdy8;
  endfunction

  function automatic logic get_ov(input int sel);
    return (sel == 1) ? ov4 : ov8;
  endfunction

  function automatic logic [7:0] get_res(input int sel);
    return (sel == 1) ? {4'h0, res4} : res8;
  endfunction

  // Carry-less product followed by polynomial long division.
  function automatic logic [7:0] gf_mul(input int w, input logic [8:0] poly,
                                        input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < w; i++)
      if (b[i]) prod ^= (16'(a) << i);
    for (int i = 2 * w - 2; i >= w; i--)
      if (prod[i]) prod ^= (16'(poly) << (i - w));
    return prod[7:0];
  endfunction

  task automatic model_op(input int sel, input logic [1:0] o, input logic [7:0] a,
                          input logic [7:0] b, output logic [7:0] exp, output int lat);
    int         w;
    logic [7:0] mask, am, bm, p;
    w    = (sel == 1) ? 4 : 8;
    mask = (sel == 1) ? 8'h0F : 8'hFF;
    am   = a & mask;
    bm   = b & mask;
    p    = gf_mul(w, (sel == 1) ? 9'h013 : 9'h11B, am, bm);
    case (o)
      2'd0: begin exp = am ^ bm; lat = 1; end
      2'd1: begin exp = p; lat = w + 1; end
      2'd2: begin
`ifdef AES_GF_MAC_ACC_EN
        m_acc[sel] = m_acc[sel] ^ p;
        exp = m_acc[sel];
`else
        exp = p;
`endif
        lat = w + 1;
      end
      default: begin
        m_acc[sel] = 8'h00;
        exp = 8'h00;
        lat = 1;
      end
    endcase
  endtask

  task automatic set_valid(input int sel, input logic v);
    if (sel == 1) v4 = v;
    else          v8 = v;
  endtask

  // Issue one request, measure edges from acceptance to out_valid, then complete the handshake.
  task automatic run_op(input int sel, input logic [1:0] o, input logic [7:0] a,
                        input logic [7:0] b, input string tag);
    logic [7:0] exp;
    int         exp_lat, lat;
    model_op(sel, o, a, b, exp, exp_lat);
    @(negedge clk);
    a_i = a; b_i = b; op = o;
    set_valid(sel, 1'b1);
    check({tag, "_ready"}, 32'(get_rdy(sel)), 32'd1);
    @(posedge clk); #1;
    set_valid(sel, 1'b0);
    a_i = 8'($urandom); b_i = 8'($urandom); op = 2'($urandom);
    lat = 1;
    while (!get_ov(sel) && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, 32'(get_res(sel)), 32'(exp));
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check({tag, "_idle"}, {31'd0, get_rdy(sel)} | {30'd0, get_ov(sel), 1'b0}, 32'd1);
  endtask

  initial begin
    logic [7:0] exp, hold;
    int         exp_lat, lat;

    rst = 1'b1; a_i = '0; b_i = '0; op = '0; v8 = 1'b0; v4 = 1'b0; ordy = 1'b0;
    m_acc[0] = '0; m_acc[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_rdy8", 32'(rdy8), 32'd1);
    check("rst_ov8",  32'(ov8),  32'd0);
    check("rst_res8", 32'(res8), 32'd0);
    check("rst_rdy4", 32'(rdy4), 32'd1);
    check("rst_ov4",  32'(ov4),  32'd0);
    check("rst_res4", 32'(res4), 32'd0);

    // Directed scenarios.
    run_op(0, 2'd1, 8'h57, 8'h83, "mul8_57x83");
    check("mul8_c1", 32'(res8), 32'hC1);
    run_op(1, 2'd0, 8'h0A, 8'h06, "sum4");
    check("sum4_c", 32'(res4), 32'hC);
    run_op(1, 2'd1, 8'h03, 8'h07, "mul4");
    check("mul4_9", 32'(res4), 32'h9);
    run_op(0, 2'd3, 8'h00, 8'h00, "clr8");
    run_op(0, 2'd2, 8'h57, 8'h83, "mac8_a");
    run_op(0, 2'd2, 8'h57, 8'h13, "mac8_b");
    run_op(0, 2'd1, 8'h00, 8'h9D, "mul8_zero_a");
    run_op(0, 2'd1, 8'hFF, 8'h00, "mul8_zero_b");
    run_op(1, 2'd1, 8'h0F, 8'h0F, "mul4_ff");

    // Output back-pressure with a competing request held on the inputs.
    model_op(0, 2'd1, 8'h12, 8'h34, exp, exp_lat);
    @(negedge clk);
    a_i = 8'h12; b_i = 8'h34; op = 2'd1; v8 = 1'b1;
    @(posedge clk); #1;
    a_i = 8'h0A; b_i = 8'h0B;
    lat = 1;
    while (!ov8 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 32'(lat), 32'(exp_lat));
    check("bp_res", 32'(res8), 32'(exp));
    hold = exp;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res", 32'(res8), 32'(hold));
      check("bp_hold_rdy", 32'(rdy8), 32'd0);
      check("bp_hold_ov",  32'(ov8),  32'd1);
    end
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check("bp_after_rdy", 32'(rdy8), 32'd1);
    check("bp_after_ov",  32'(ov8),  32'd0);
    model_op(0, 2'd1, 8'h0A, 8'h0B, exp, exp_lat);
    @(posedge clk); #1;
    v8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_next_lat", 32'(lat), 32'(exp_lat));
    check("bp_next_res", 32'(res8), 32'(exp));
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;

    // Reset during the third BUSY cycle of a MUL.
    @(negedge clk);
    a_i = 8'h57; b_i = 8'h83; op = 2'd1; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc[0] = '0; m_acc[1] = '0;
    check("abort_rdy", 32'(rdy8), 32'd1);
    check("abort_ov",  32'(ov8),  32'd0);
    check("abort_res", 32'(res8), 32'd0);
    run_op(0, 2'd0, 8'h01, 8'h01, "abort_sum");
    run_op(0, 2'd2, 8'h01, 8'h01, "abort_mac");

    // Randomized mix on both instances.
    for (int i = 0; i < 40; i++) begin
      int         sel;
      logic [1:0] o;
      sel = int'($urandom_range(0, 1));
      o   = 2'($urandom_range(0, 3));
      run_op(sel, o, 8'($urandom), 8'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/aes_gf_mac.md
AES_GF_MAC -- requirements
Module: aes_gf_mac

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the field element width in bits for GF(2^WIDTH); legal values are 2..8.
REQ-002 The block SHALL have parameter POLY, default 9'h11B, width WIDTH+1, giving the irreducible reduction polynomial with bit WIDTH set.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port operand_a_i, input, WIDTH bits: field element A.
REQ-006 The block SHALL have port operand_b_i, input, WIDTH bits: field element B.
REQ-007 The block SHALL have port op_i, input, 2 bits: operation select; 0=SUM, 1=MUL, 2=MAC, 3=CLR.
REQ-008 The block SHALL have port in_valid_i, input, 1 bit: operands and op_i are valid.
REQ-009 The block SHALL have port in_ready_o, output, 1 bit: the block accepts a request this cycle.
REQ-010 The block SHALL have port result_o, output, WIDTH bits: operation result.
REQ-011 The block SHALL have port out_valid_o, output, 1 bit: result_o is valid.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit: the consumer accepts result_o.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-014 in_ready_o SHALL be 1 only in IDLE; out_valid_o SHALL be 1 only in DONE.
REQ-015 A request SHALL be accepted on a rising edge where in_valid_i=1 and in_ready_o=1; operands and op SHALL be registered at that edge, and later input changes SHALL have no effect.
REQ-016 SUM SHALL go IDLE->DONE with result = A XOR B, latency 1 cycle.
REQ-017 CLR SHALL go IDLE->DONE, clear the accumulator to 0 and give result 0, latency 1 cycle.
REQ-018 MUL and MAC SHALL go IDLE->BUSY, then iterate exactly WIDTH BUSY cycles over B, MSB first.
REQ-019 Each BUSY cycle SHALL compute p <= xtime(p) XOR (b[i] ? A : 0), where xtime is a left shift reduced by POLY when the shifted-out bit is 1.
REQ-020 After the last BUSY cycle the FSM SHALL go BUSY->DONE, so out_valid_o rises WIDTH+1 cycles after acceptance.
REQ-021 MUL SHALL give result = A*B mod POLY; the accumulator SHALL remain unchanged.
REQ-022 MAC SHALL update acc <= acc XOR (A*B) on entering DONE and SHALL give result = the new acc value.
REQ-023 DONE SHALL hold result_o and out_valid_o stable until out_ready_i=1, then go DONE->IDLE; no new request SHALL be accepted in the same cycle.
REQ-024 If A=0 or B=0, MUL SHALL still take WIDTH BUSY cycles, because latency is data-independent for constant-time behaviour.
REQ-025 in_valid_i SHALL be ignored in BUSY and DONE.

Reset
REQ-026 rst_i=1 at a rising edge SHALL force IDLE, accumulator=0, result_o=0, out_valid_o=0 and in_ready_o=1 from the next cycle.
REQ-027 Reset SHALL abort any in-flight BUSY or DONE operation with no result produced, and it SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-028 Macro AES_GF_MAC_ACC_EN defined SHALL compile in the accumulator register and the MAC and CLR behaviour described above.
REQ-029 With AES_GF_MAC_ACC_EN undefined, no accumulator register SHALL exist, MAC SHALL behave exactly as MUL, and CLR SHALL complete in 1 cycle with result 0.

Verification
REQ-030 Scenario: WIDTH=8, POLY=0x11B, MUL A=0x57 B=0x83 -> result 0xC1, out_valid_o rising 9 cycles after acceptance.
REQ-031 Scenario: WIDTH=4, POLY=0x13, SUM 0xA,0x6 -> result 0xC after 1 cycle; MUL 0x3,0x7 -> result 0x9 after 5 cycles.
REQ-032 Scenario: with ACC_EN, CLR, then MAC 0x57*0x83, then MAC 0x57*0x13 -> results 0x00, 0xC1, 0x3F (0xC1 XOR 0xFE).
REQ-033 Scenario: hold out_ready_i=0 for 10 cycles in DONE while in_valid_i=1 with new operands -> result_o stable, in_ready_o=0, the new request not accepted until after the output handshake.
REQ-034 Scenario: assert rst_i in the 3rd BUSY cycle of a MUL -> next cycle IDLE, out_valid_o=0, accumulator 0; a following SUM 0x01,0x01 -> result 0x00.
REQ-035 Scenario: without ACC_EN, MAC 0x57,0x83 twice -> both results 0xC1.
